// File: rtl/audio_mix_dac.sv
// audio_mix_dac: N-channel sequential audio mixer with per-channel enable and
// shift attenuation, a saturating sum, clip/overrun status, and a first-order
// sigma-delta 1-bit DAC that plays the most recent mixed sample.
module audio_mix_dac #(
  parameter int NCH   = 4,
  parameter int IN_W  = 14,
  parameter int OUT_W = 15
) (
  input  logic                clk_i,
  input  logic                res_n_i,
  input  logic                ce_i,
  input  logic [NCH*IN_W-1:0] ch_data_i,
  input  logic [NCH-1:0]      ch_en_i,
  input  logic [NCH*3-1:0]    ch_att_i,
  output logic [OUT_W-1:0]    mix_o,
  output logic                mix_valid_o,
  output logic                clip_o,
  output logic                overrun_o,
  output logic                dac_o
);

  // The accumulator gets one headroom bit beyond the worst-case channel sum.
  localparam int SW    = IN_W + ((NCH > 1) ? $clog2(NCH) : 0) + 1;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  // The comparison width covers both the accumulator and the full-scale output.
  localparam int CW    = (SW > OUT_W + 1) ? SW : OUT_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
  localparam logic [CW-1:0]    MAX_EXT  = (CW'(1) << OUT_W) - CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [SW-1:0]     acc_reg, acc_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [OUT_W-1:0]  mix_reg, mix_next;
  logic              valid_reg, valid_next;
  logic              clip_reg, clip_next;
  logic              overrun_reg, overrun_next;
  logic              snap_load;

  // Snapshot of the channel inputs taken on the accepted strobe, so the
  // sources are free to change while the pass walks the channels.
  logic [IN_W-1:0]   data_snap_reg [NCH];
  logic [2:0]        att_snap_reg  [NCH];
  logic [NCH-1:0]    en_snap_reg;

  logic [SW-1:0]     term [NCH];
  logic [SW-1:0]     sel_term;
  logic [CW-1:0]     acc_ext;
  logic              over_max;

  logic [OUT_W:0]    sd_reg, sd_next;
  logic              dac_reg;

  // Per-channel contribution: logical right shift of the snapshot sample,
  // forced to zero when the channel is disabled.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_term
      assign term[gi] = en_snap_reg[gi] ? SW'(data_snap_reg[gi] >> att_snap_reg[gi]) : '0;
    end
  endgenerate

  // Select the contribution of the channel currently being accumulated.
  always_comb begin
    sel_term = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        sel_term = term[i];
      end
    end
  end

  // Saturation detect against the largest value mix_o can carry.
  always_comb begin
    acc_ext  = CW'(acc_reg);
    over_max = (acc_ext > MAX_EXT);
  end

  // Next-state and datapath control for the IDLE -> ACC -> SAT pass.
  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    idx_next     = idx_reg;
    mix_next     = mix_reg;
    clip_next    = clip_reg;
    valid_next   = 1'b0;
    overrun_next = 1'b0;
    snap_load    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ce_i) begin
          snap_load  = 1'b1;
          acc_next   = '0;
          idx_next   = '0;
          state_next = ACC;
        end
      end
      ACC: begin
        overrun_next = ce_i;
        acc_next     = acc_reg + sel_term;
        if (idx_reg == LAST_IDX) begin
          state_next = SAT;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      SAT: begin
        overrun_next = ce_i;
        valid_next   = 1'b1;
        if (over_max) begin
          mix_next  = '1;
          clip_next = 1'b1;
        end else begin
          mix_next  = acc_ext[OUT_W-1:0];
          clip_next = 1'b0;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state, accumulator and status registers.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      idx_reg     <= '0;
      mix_reg     <= '0;
      valid_reg   <= 1'b0;
      clip_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      idx_reg     <= idx_next;
      mix_reg     <= mix_next;
      valid_reg   <= valid_next;
      clip_reg    <= clip_next;
      overrun_reg <= overrun_next;
    end
  end

  // Capture channel data, enables and attenuations when a pass starts.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      for (int i = 0; i < NCH; i++) begin
        data_snap_reg[i] <= '0;
        att_snap_reg[i]  <= '0;
      end
      en_snap_reg <= '0;
    end else if (snap_load) begin
      for (int i = 0; i < NCH; i++) begin
        data_snap_reg[i] <= ch_data_i[i*IN_W +: IN_W];
        att_snap_reg[i]  <= ch_att_i[i*3 +: 3];
      end
      en_snap_reg <= ch_en_i;
    end
  end

  // First-order sigma-delta: the carry out of the phase accumulator is the
  // bitstream, so its density tracks mix_o / 2^OUT_W.
  always_comb begin
    sd_next = {1'b0, sd_reg[OUT_W-1:0]} + {1'b0, mix_reg};
  end

  // Sigma-delta accumulator and output bit, running every clock.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      sd_reg  <= '0;
      dac_reg <= 1'b0;
    end else begin
      sd_reg  <= sd_next;
      dac_reg <= sd_reg[OUT_W];
    end
  end

  assign mix_o       = mix_reg;
  assign mix_valid_o = valid_reg;
  assign clip_o      = clip_reg;
  assign overrun_o   = overrun_reg;
  assign dac_o       = dac_reg;

endmodule

// File: tb/tb_audio_mix_dac.sv
// Directed testbench for audio_mix_dac with hand-computed expected values.
module tb_audio_mix_dac;

  localparam int NCH   = 4;
  localparam int IN_W  = 14;
  localparam int OUT_W = 15;

  logic                clk_i = 1'b0;
  logic                res_n_i;
  logic                ce_i;
  logic [NCH*IN_W-1:0] ch_data_i;
  logic [NCH-1:0]      ch_en_i;
  logic [NCH*3-1:0]    ch_att_i;
  logic [OUT_W-1:0]    mix_o;
  logic                mix_valid_o;
  logic                clip_o;
  logic                overrun_o;
  logic                dac_o;

  int vectors = 0;
  int miscompares = 0;

  audio_mix_dac #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk_i       (clk_i),
    .res_n_i     (res_n_i),
    .ce_i        (ce_i),
    .ch_data_i   (ch_data_i),
    .ch_en_i     (ch_en_i),
    .ch_att_i    (ch_att_i),
    .mix_o       (mix_o),
    .mix_valid_o (mix_valid_o),
    .clip_o      (clip_o),
    .overrun_o   (overrun_o),
    .dac_o       (dac_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [NCH*IN_W-1:0] pack_data(input int c0, input int c1, input int c2, input int c3);
    return {IN_W'(c3), IN_W'(c2), IN_W'(c1), IN_W'(c0)};
  endfunction

  function automatic logic [NCH*3-1:0] pack_att(input int a0, input int a1, input int a2, input int a3);
    return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  // One pass started in cycle 0; inputs are scrambled afterwards to show the
  // snapshot is used. Ends in cycle 7 with the FSM idle.
  task automatic run_pass(input string tag, input logic [NCH*IN_W-1:0] d, input logic [NCH-1:0] e,
                          input logic [NCH*3-1:0] a, input int exp_mix, input int exp_clip);
    ch_data_i = d;
    ch_en_i   = e;
    ch_att_i  = a;
    ce_i      = 1'b1;
    step();
    ce_i      = 1'b0;
    ch_data_i = '1;
    ch_en_i   = '1;
    ch_att_i  = '0;
    repeat (4) step();
    check({tag, " valid_c5"}, 32'(mix_valid_o), 0);
    step();
    check({tag, " valid_c6"}, 32'(mix_valid_o), 1);
    check({tag, " mix"}, 32'(mix_o), 32'(exp_mix));
    check({tag, " clip"}, 32'(clip_o), 32'(exp_clip));
    step();
    check({tag, " valid_c7"}, 32'(mix_valid_o), 0);
    check({tag, " mix_hold"}, 32'(mix_o), 32'(exp_mix));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int vcnt;

    // Reset defaults: inputs toggling under reset must not move any output.
    res_n_i   = 1'b0;
    ce_i      = 1'b0;
    ch_data_i = '0;
    ch_en_i   = '0;
    ch_att_i  = '0;
    for (int i = 0; i < 4; i++) begin
      ce_i      = i[0];
      ch_data_i = pack_data(16383, 1000 * i, 5, 16383);
      ch_en_i   = 4'hF;
      step();
      check("rst mix", 32'(mix_o), 0);
      check("rst valid", 32'(mix_valid_o), 0);
      check("rst clip", 32'(clip_o), 0);
      check("rst overrun", 32'(overrun_o), 0);
      check("rst dac", 32'(dac_o), 0);
    end
    ce_i    = 1'b0;
    res_n_i = 1'b1;
    step();
    check("post_rst valid", 32'(mix_valid_o), 0);

    // Basic sum and latency.
    run_pass("sum", pack_data(1000, 2000, 3000, 4000), 4'hF, pack_att(0, 0, 0, 0), 10000, 0);

    // Saturation, then recovery clears the sticky clip.
    run_pass("sat", pack_data(16383, 16383, 16383, 16383), 4'hF, pack_att(0, 0, 0, 0), 32767, 1);
    run_pass("unsat", pack_data(100, 100, 100, 100), 4'hF, pack_att(0, 0, 0, 0), 400, 0);

    // Enable mask and attenuation: ch0>>2 + ch2>>1 of 8192.
    run_pass("en_att", pack_data(8192, 8192, 8192, 8192), 4'b0101, pack_att(2, 3, 1, 0), 6144, 0);

    // Maximum shift keeps the top 7 bits of a full-scale sample.
    run_pass("att7", pack_data(16383, 0, 0, 0), 4'b0001, pack_att(7, 0, 0, 0), 127, 0);

    // Overrun: strobes at cycles 0 and 3, then accepted strobe at cycle 7.
    vcnt = 0;
    ch_data_i = pack_data(1000, 2000, 3000, 4000);
    ch_en_i   = 4'hF;
    ch_att_i  = pack_att(0, 0, 0, 0);
    ce_i      = 1'b1;
    step();
    ce_i = 1'b0;
    vcnt += int'(mix_valid_o);
    step();
    vcnt += int'(mix_valid_o);
    step();
    vcnt += int'(mix_valid_o);
    ch_data_i = pack_data(100, 100, 100, 100);
    ce_i = 1'b1;
    step();
    ce_i = 1'b0;
    vcnt += int'(mix_valid_o);
    check("ovr pulse_c4", 32'(overrun_o), 1);
    step();
    vcnt += int'(mix_valid_o);
    check("ovr pulse_c5", 32'(overrun_o), 0);
    step();
    vcnt += int'(mix_valid_o);
    check("ovr valid_c6", 32'(mix_valid_o), 1);
    check("ovr mix", 32'(mix_o), 10000);
    step();
    vcnt += int'(mix_valid_o);
    check("ovr single_valid", 32'(vcnt), 1);
    ce_i = 1'b1;
    step();
    ce_i = 1'b0;
    check("ovr c7_no_overrun", 32'(overrun_o), 0);
    repeat (5) step();
    check("ovr c7_valid", 32'(mix_valid_o), 1);
    check("ovr c7_mix", 32'(mix_o), 400);
    step();

    // DAC density with mix_o = 8192 held.
    run_pass("dac8192", pack_data(8192, 0, 0, 0), 4'b0001, pack_att(0, 0, 0, 0), 8192, 0);
    repeat (3) step();
    cnt = 0;
    for (int i = 0; i < 32768; i++) begin
      step();
      cnt += int'(dac_o);
    end
    check("dac density_8192", 32'((cnt >= 8191) && (cnt <= 8193)), 1);

    // Reset in the middle of ACC aborts the pass.
    ch_data_i = pack_data(1000, 1000, 1000, 1000);
    ch_en_i   = 4'hF;
    ce_i      = 1'b1;
    step();
    ce_i = 1'b0;
    step();
    res_n_i = 1'b0;
    #1;
    check("midrst mix", 32'(mix_o), 0);
    check("midrst dac", 32'(dac_o), 0);
    step();
    res_n_i = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      vcnt += int'(mix_valid_o);
    end
    check("midrst no_valid", 32'(vcnt), 0);
    check("midrst mix_after", 32'(mix_o), 0);

    // mix_o = 0 gives a silent bitstream.
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      cnt += int'(dac_o);
    end
    check("dac density_0", 32'(cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
